// File: rtl/st_demux_pkg.sv
// Shared constants for the packet-aware stream demultiplexer.
package st_demux_pkg;

    // Route encoding carried on `sel` and `route`.
    localparam logic ROUTE_A = 1'b0;
    localparam logic ROUTE_B = 1'b1;

    // Default widths for the demux top level.
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_CNT_WIDTH  = 16;

endpackage

// File: rtl/st_output_slice.sv
// One-entry AXI-Stream register slice: holds data/last/valid for one branch.
// `space` tells the producer a new beat can be loaded this cycle.
module st_output_slice #(
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DataWidth-1:0] load_data,
    input  logic                 load_last,
    input  logic                 ready,
    output logic [DataWidth-1:0] data,
    output logic                 last,
    output logic                 valid,
    output logic                 space
);

    // Free when empty or when the held beat drains this cycle.
    assign space = !valid || ready;

    // Load a new beat, or clear valid when the held beat drains with nothing new behind it.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values;
        // data/last are reset as well because the branch outputs must read 0 after reset.
        if (reset) begin
            data  <= '0;
            last  <= 1'b0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            last  <= load_last;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/one_to_two_st_demux.sv
// Packet-aware 1-to-2 AXI-Stream demultiplexer. The route is latched on the
// first beat of each packet and held until tlast, so `sel` only matters at
// packet boundaries. Each branch has a register slice and a delivered-packet counter.
module one_to_two_st_demux
    import st_demux_pkg::*;
#(
    parameter int DataWidth = DEFAULT_DATA_WIDTH,
    parameter int CntWidth  = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sel,
    input  logic [DataWidth-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    output logic [DataWidth-1:0] m_axis_tdata_A,
    output logic                 m_axis_tvalid_A,
    output logic                 m_axis_tlast_A,
    input  logic                 m_axis_tready_A,
    output logic [DataWidth-1:0] m_axis_tdata_B,
    output logic                 m_axis_tvalid_B,
    output logic                 m_axis_tlast_B,
    input  logic                 m_axis_tready_B,
    output logic                 route,
    output logic                 in_pkt,
    output logic [CntWidth-1:0]  pkt_count_A,
    output logic [CntWidth-1:0]  pkt_count_B
);

    logic eff_route;
    logic accept;
    logic load_a;
    logic load_b;
    logic space_a;
    logic space_b;

    // Choose the target branch (latched route mid-packet, live sel otherwise) and steer ready/load.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        eff_route     = sel;
        s_axis_tready = space_a;
        accept        = 1'b0;
        load_a        = 1'b0;
        load_b        = 1'b0;
        if (in_pkt) begin
            eff_route = route;
        end
        s_axis_tready = (eff_route == ROUTE_A) ? space_a : space_b;
        accept        = s_axis_tvalid && s_axis_tready;
        load_a        = accept && (eff_route == ROUTE_A);
        load_b        = accept && (eff_route == ROUTE_B);
    end

    // Track packet framing: latch the route on a first beat, leave the packet on tlast.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_pkt <= 1'b0;
            route  <= ROUTE_A;
        end else if (accept) begin
            if (!in_pkt) begin
                route <= sel;
            end
            in_pkt <= !s_axis_tlast;
        end
    end

    // Count packets whose final beat has been handed to each consumer; wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count_A <= '0;
            pkt_count_B <= '0;
        end else begin
            if (m_axis_tvalid_A && m_axis_tready_A && m_axis_tlast_A) begin
                pkt_count_A <= pkt_count_A + CntWidth'(1);
            end
            if (m_axis_tvalid_B && m_axis_tready_B && m_axis_tlast_B) begin
                pkt_count_B <= pkt_count_B + CntWidth'(1);
            end
        end
    end

    st_output_slice #(
        .DataWidth(DataWidth)
    ) u_slice_a (
        .clk      (clk),
        .reset    (reset),
        .load     (load_a),
        .load_data(s_axis_tdata),
        .load_last(s_axis_tlast),
        .ready    (m_axis_tready_A),
        .data     (m_axis_tdata_A),
        .last     (m_axis_tlast_A),
        .valid    (m_axis_tvalid_A),
        .space    (space_a)
    );

    st_output_slice #(
        .DataWidth(DataWidth)
    ) u_slice_b (
        .clk      (clk),
        .reset    (reset),
        .load     (load_b),
        .load_data(s_axis_tdata),
        .load_last(s_axis_tlast),
        .ready    (m_axis_tready_B),
        .data     (m_axis_tdata_B),
        .last     (m_axis_tlast_B),
        .valid    (m_axis_tvalid_B),
        .space    (space_b)
    );

endmodule

// File: tb/tb_one_to_two_st_demux.sv
// Self-checking bench for one_to_two_st_demux: a packet-level model (per-branch
// holding queues plus packet framing) is compared against the DUT every cycle,
// and directed scenarios pin delivered sequences and counts with literal values.
module tb_one_to_two_st_demux;

    localparam int DW    = 32;
    localparam int CNT_W = 8;   // narrow counters so the wrap case stays short

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sel = 1'b0;
    logic [DW-1:0]    s_tdata = '0;
    logic             s_tvalid = 1'b0;
    logic             s_tready;
    logic             s_tlast = 1'b0;
    logic [DW-1:0]    a_tdata;
    logic             a_tvalid;
    logic             a_tlast;
    logic             a_tready = 1'b1;
    logic [DW-1:0]    b_tdata;
    logic             b_tvalid;
    logic             b_tlast;
    logic             b_tready = 1'b1;
    logic             route;
    logic             in_pkt;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model state
    beat_t m_reg_a[$];
    beat_t m_reg_b[$];
    logic  m_in_pkt = 1'b0;
    logic  m_route  = 1'b0;
    int    m_cnt_a  = 0;
    int    m_cnt_b  = 0;

    // Observation logs and flags
    logic [DW-1:0] log_a[$];
    logic [DW-1:0] log_b[$];
    logic [DW-1:0] exp_q[$];
    logic saw_stall  = 1'b0;
    logic saw_in_pkt = 1'b0;
    logic b_seen     = 1'b0;

    logic exp_va, exp_vb, sp_a, sp_b, eff, exp_rdy;

    one_to_two_st_demux #(
        .DataWidth(DW),
        .CntWidth (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sel            (sel),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tready  (s_tready),
        .s_axis_tlast   (s_tlast),
        .m_axis_tdata_A (a_tdata),
        .m_axis_tvalid_A(a_tvalid),
        .m_axis_tlast_A (a_tlast),
        .m_axis_tready_A(a_tready),
        .m_axis_tdata_B (b_tdata),
        .m_axis_tvalid_B(b_tvalid),
        .m_axis_tlast_B (b_tlast),
        .m_axis_tready_B(b_tready),
        .route          (route),
        .in_pkt         (in_pkt),
        .pkt_count_A    (cnt_a),
        .pkt_count_B    (cnt_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_log(input string name, input logic [DW-1:0] got[$], input logic [DW-1:0] exp[$]);
        check({name, "_len"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            check($sformatf("%s[%0d]", name, i), 64'(got[i]), 64'(exp[i]));
        end
    endtask

    // Per-cycle compare against the model, then advance the model across the coming edge.
    always @(negedge clk) begin
        exp_va = (m_reg_a.size() != 0);
        exp_vb = (m_reg_b.size() != 0);
        check("tvalid_a", 64'(a_tvalid), 64'(exp_va));
        check("tvalid_b", 64'(b_tvalid), 64'(exp_vb));
        if (exp_va) begin
            check("tdata_a", 64'(a_tdata), 64'(m_reg_a[0].data));
            check("tlast_a", 64'(a_tlast), 64'(m_reg_a[0].last));
        end
        if (exp_vb) begin
            check("tdata_b", 64'(b_tdata), 64'(m_reg_b[0].data));
            check("tlast_b", 64'(b_tlast), 64'(m_reg_b[0].last));
        end
        check("in_pkt", 64'(in_pkt), 64'(m_in_pkt));
        if (m_in_pkt) check("route", 64'(route), 64'(m_route));
        check("cnt_a", 64'(cnt_a), 64'(m_cnt_a));
        check("cnt_b", 64'(cnt_b), 64'(m_cnt_b));
        sp_a    = !exp_va || a_tready;
        sp_b    = !exp_vb || b_tready;
        eff     = m_in_pkt ? m_route : sel;
        exp_rdy = eff ? sp_b : sp_a;
        check("s_tready", 64'(s_tready), 64'(exp_rdy));

        if (s_tvalid && !exp_rdy) saw_stall = 1'b1;
        if (in_pkt) saw_in_pkt = 1'b1;
        if (b_tvalid) b_seen = 1'b1;

        if (reset) begin
            m_reg_a.delete();
            m_reg_b.delete();
            m_in_pkt = 1'b0;
            m_route  = 1'b0;
            m_cnt_a  = 0;
            m_cnt_b  = 0;
        end else begin
            if (a_tvalid && a_tready) log_a.push_back(a_tdata);
            if (b_tvalid && b_tready) log_b.push_back(b_tdata);
            if (exp_va && a_tready) begin
                if (m_reg_a[0].last) m_cnt_a = (m_cnt_a + 1) % (1 << CNT_W);
                void'(m_reg_a.pop_front());
            end
            if (exp_vb && b_tready) begin
                if (m_reg_b[0].last) m_cnt_b = (m_cnt_b + 1) % (1 << CNT_W);
                void'(m_reg_b.pop_front());
            end
            if (s_tvalid && exp_rdy) begin
                if (eff) m_reg_b.push_back('{data: s_tdata, last: s_tlast});
                else     m_reg_a.push_back('{data: s_tdata, last: s_tlast});
                if (!m_in_pkt) m_route = sel;
                m_in_pkt = !s_tlast;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until the DUT accepts it (bounded).
    task automatic send(input logic [DW-1:0] d, input logic l, input logic s);
        logic got;
        s_tdata  = d;
        s_tlast  = l;
        sel      = s;
        s_tvalid = 1'b1;
        for (int i = 0; ; i++) begin
            @(negedge clk);
            got = s_tready;
            step();
            if (got) break;
            if (i >= 200) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout: beat 0x%0h not accepted within 200 cycles", d);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (n) step();
    endtask

    task automatic reset_dut();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
        log_a.delete();
        log_b.delete();
        saw_stall  = 1'b0;
        saw_in_pkt = 1'b0;
        b_seen     = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tvalid_a"}, 64'(a_tvalid), 64'd0);
        check({tag, "_tdata_a"},  64'(a_tdata),  64'd0);
        check({tag, "_tlast_a"},  64'(a_tlast),  64'd0);
        check({tag, "_tvalid_b"}, 64'(b_tvalid), 64'd0);
        check({tag, "_tdata_b"},  64'(b_tdata),  64'd0);
        check({tag, "_tlast_b"},  64'(b_tlast),  64'd0);
        check({tag, "_route"},    64'(route),    64'd0);
        check({tag, "_in_pkt"},   64'(in_pkt),   64'd0);
        check({tag, "_cnt_a"},    64'(cnt_a),    64'd0);
        check({tag, "_cnt_b"},    64'(cnt_b),    64'd0);
        check({tag, "_s_tready"}, 64'(s_tready), 64'd1);
    endtask

    initial begin
        int c0;

        // Reset state
        a_tready = 1'b1;
        b_tready = 1'b1;
        reset_dut();
        @(negedge clk);
        check_all_zero("rst");
        step();

        // 4-beat packet 1..4 to A at full rate, 1-cycle latency
        send(32'd1, 1'b0, 1'b0);
        check("lat_tvalid_a", 64'(a_tvalid), 64'd1);
        check("lat_tdata_a",  64'(a_tdata),  64'd1);
        send(32'd2, 1'b0, 1'b0);
        send(32'd3, 1'b0, 1'b0);
        send(32'd4, 1'b1, 1'b0);
        idle(3);
        exp_q = {32'd1, 32'd2, 32'd3, 32'd4};
        check_log("t1_log_a", log_a, exp_q);
        check("t1_cnt_a", 64'(cnt_a), 64'd1);
        check("t1_model_cnt_a", 64'(m_cnt_a), 64'd1);
        check("t1_b_seen", 64'(b_seen), 64'd0);

        // sel toggles mid-packet (including on tlast): whole packet stays on A, next goes to B
        reset_dut();
        send(32'h11, 1'b0, 1'b0);
        send(32'h12, 1'b0, 1'b1);
        send(32'h13, 1'b0, 1'b1);
        send(32'h14, 1'b1, 1'b1);
        send(32'h21, 1'b0, 1'b1);
        send(32'h22, 1'b0, 1'b0);
        send(32'h23, 1'b0, 1'b0);
        send(32'h24, 1'b1, 1'b0);
        idle(3);
        exp_q = {32'h11, 32'h12, 32'h13, 32'h14};
        check_log("t2_log_a", log_a, exp_q);
        exp_q = {32'h21, 32'h22, 32'h23, 32'h24};
        check_log("t2_log_b", log_b, exp_q);
        check("t2_cnt_a", 64'(cnt_a), 64'd1);
        check("t2_cnt_b", 64'(cnt_b), 64'd1);

        // ready_A low for 4 cycles mid-packet: input stalls, nothing lost
        reset_dut();
        fork
            begin
                send(32'h31, 1'b0, 1'b0);
                send(32'h32, 1'b0, 1'b0);
                send(32'h33, 1'b0, 1'b0);
                send(32'h34, 1'b0, 1'b0);
                send(32'h35, 1'b0, 1'b0);
                send(32'h36, 1'b1, 1'b0);
            end
            begin
                step();
                step();
                a_tready = 1'b0;
                repeat (4) step();
                a_tready = 1'b1;
            end
        join
        idle(3);
        exp_q = {32'h31, 32'h32, 32'h33, 32'h34, 32'h35, 32'h36};
        check_log("t3_log_a", log_a, exp_q);
        check("t3_saw_stall", 64'(saw_stall), 64'd1);
        check("t3_cnt_a", 64'(cnt_a), 64'd1);

        // A's tlast beat stalled while B streams at full rate
        reset_dut();
        a_tready = 1'b0;
        send(32'h41, 1'b1, 1'b0);
        c0 = cyc;
        send(32'h51, 1'b0, 1'b1);
        send(32'h52, 1'b0, 1'b1);
        send(32'h53, 1'b0, 1'b1);
        send(32'h54, 1'b1, 1'b1);
        check("t4_b_cycles", 64'(cyc - c0), 64'd4);
        idle(2);
        check("t4_held_valid_a", 64'(a_tvalid), 64'd1);
        check("t4_held_tlast_a", 64'(a_tlast),  64'd1);
        check("t4_held_tdata_a", 64'(a_tdata),  64'h41);
        check("t4_cnt_a_held",   64'(cnt_a),    64'd0);
        check("t4_cnt_b",        64'(cnt_b),    64'd1);
        exp_q = {32'h51, 32'h52, 32'h53, 32'h54};
        check_log("t4_log_b", log_b, exp_q);
        a_tready = 1'b1;
        idle(2);
        check("t4_cnt_a", 64'(cnt_a), 64'd1);

        // Single-beat packets alternating sel: 3 per branch, in_pkt never rises
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            send(32'h61 + DW'(i), 1'b1, i[0]);
        end
        idle(3);
        check("t5_saw_in_pkt", 64'(saw_in_pkt), 64'd0);
        check("t5_cnt_a", 64'(cnt_a), 64'd3);
        check("t5_cnt_b", 64'(cnt_b), 64'd3);
        exp_q = {32'h61, 32'h63, 32'h65};
        check_log("t5_log_a", log_a, exp_q);
        exp_q = {32'h62, 32'h64, 32'h66};
        check_log("t5_log_b", log_b, exp_q);

        // Reset on beat 2 of a packet held in B: everything clears, partial packet not counted
        reset_dut();
        b_tready = 1'b0;
        s_tdata  = 32'h71;
        s_tlast  = 1'b0;
        sel      = 1'b1;
        s_tvalid = 1'b1;
        step();
        s_tdata  = 32'h72;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
        s_tvalid = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        b_tready = 1'b1;
        idle(3);
        check("t6_cnt_b", 64'(cnt_b), 64'd0);

        // Counter wrap: bring cnt_b to all-ones (0xFF) then one more packet gives 0
        reset_dut();
        for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
            send(DW'(i), 1'b1, 1'b1);
        end
        idle(2);
        check("t7_cnt_b_full", 64'(cnt_b), 64'hFF);
        send(32'hAB, 1'b1, 1'b1);
        idle(2);
        check("t7_cnt_b_wrap", 64'(cnt_b), 64'd0);
        check("t7_cnt_a", 64'(cnt_a), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/one_to_two_st_demux.md
# one_to_two_st_demux

Packet-aware 1-to-2 AXI-Stream demultiplexer; the counterpart of the 2-to-1 stream mux. It takes one slave stream and routes each whole packet to output A or output B according to `sel`. The route is sampled only at packet boundaries, so `sel` is ignored mid-packet. Each output has a one-stage register slice and a delivered-packet counter. It sits between a single stream producer (e.g. `streamer_up`) and two independent consumers.

## Interface
Parameters:
- `DataWidth`, default 32, tdata width.
- `CntWidth`, default 16, width of the per-branch packet counters.

Ports:
- `clk`, in, 1: the single clock; all logic is rising-edge.
- `reset`, in, 1: synchronous, active-high reset.
- `sel`, in, 1: route request; 0 selects A, 1 selects B. Sampled only on the first beat of a packet.
- `s_axis_tdata`, in, DataWidth: input data.
- `s_axis_tvalid`, in, 1: input valid.
- `s_axis_tready`, out, 1: input ready.
- `s_axis_tlast`, in, 1: input end of packet.
- `m_axis_tdata_A`, `m_axis_tvalid_A`, `m_axis_tlast_A`, out, DataWidth/1/1: branch A output.
- `m_axis_tready_A`, in, 1: branch A ready.
- `m_axis_tdata_B`, `m_axis_tvalid_B`, `m_axis_tlast_B`, out, DataWidth/1/1: branch B output.
- `m_axis_tready_B`, in, 1: branch B ready.
- `route`, out, 1: route of the packet in flight (valid while `in_pkt`=1).
- `in_pkt`, out, 1: high between the first and the last accepted beat of a packet.
- `pkt_count_A`, `pkt_count_B`, out, CntWidth: number of packets fully delivered on each branch.

## Operation
- An input beat is accepted when `s_axis_tvalid` & `s_axis_tready` are both high.
- Effective route: `eff_route = in_pkt ? route : sel`.
- On an accepted beat with `in_pkt`=0: `route` <= `sel`.
- On every accepted beat: `in_pkt` <= !`s_axis_tlast`.
  - A single-beat packet (tlast on its first beat) leaves `in_pkt` at 0.
- `s_axis_tready = (eff_route==0) ? (!m_axis_tvalid_A | m_axis_tready_A) : (!m_axis_tvalid_B | m_axis_tready_B)`.
  - This is combinational; it may depend on `sel` while `in_pkt`=0.
- Each branch has one output register holding data, last and valid.
  - It loads when an accepted beat targets that branch.
  - Its valid clears when it drains (valid & ready) with no new load in the same cycle.
  - Load and drain in the same cycle keeps valid high and takes the new data.
- The non-selected branch keeps its held beat until its own consumer takes it. It never blocks the selected branch.
- `pkt_count_X` increments on `m_axis_tvalid_X & m_axis_tready_X & m_axis_tlast_X`. It wraps from all-ones to 0.
- Data is never reordered, duplicated or dropped. Within a packet, beats go to exactly one branch.

## Timing
- Reset value of every output is 0:
  - all `m_axis_tvalid_*`, `m_axis_tdata_*` and `m_axis_tlast_*`;
  - `route`, `in_pkt` and both counters;
  - `s_axis_tready` then evaluates as 1.
- Latency: 1 cycle from input handshake to output valid.
- Throughput: 1 beat/cycle when the target branch's ready is held high.
- Backpressure: ready low on the target branch with its register full gives `s_axis_tready`=0 in the same cycle.
- Boundary conditions:
  - `sel` toggling mid-packet has no effect. A new `sel` value applies from the next first beat.
  - `sel` change coinciding with an accepted tlast beat: the tlast beat uses the old route and the next packet uses the new `sel`.
  - Reset mid-packet: held beats are discarded and `in_pkt`/`route` are cleared. The partial packet is not counted.
  - A tvalid drop mid-packet does not change `in_pkt`.

## Structure
- Shared package `st_demux_pkg`:
  - `ROUTE_A`=1'b0, `ROUTE_B`=1'b1;
  - default `CntWidth`.
- Sub-module `st_output_slice`: a one-entry AXI-Stream register with data, last and valid, plus a `space` output (`!valid | ready`). It is instantiated twice, once per branch.
- The top level holds the `in_pkt`/`route` state, the effective-route muxing and the two counters.

## Test plan
- 4-beat packets 1,2,3,4 (tlast on 4) with `sel`=0 and both readies high -> A outputs 1..4, one per cycle after 1-cycle latency; `pkt_count_A`=1; B never valid.
- `sel` toggles 0->1 on beat 2 of a 4-beat packet -> all 4 beats on A; the next packet goes to B; the counts end at A=1, B=1.
- Hold `m_axis_tready_A` low for 4 cycles mid-packet -> `s_axis_tready`=0 after 1 beat is held; no beat is lost; the sequence resumes intact.
- A's last beat is stalled (ready_A low) while the next packet goes to B -> B streams at full rate; A keeps tlast valid until ready_A rises.
- Single-beat packets alternating `sel` 0/1 ×6 -> 3 packets per branch; `in_pkt` stays 0 throughout.
- Reset asserted on beat 2 of a packet -> the next cycle shows all outputs at 0 and `s_axis_tready`=1. Preloading `pkt_count_B` to 0xFFFF then delivering one B packet gives 0.
